// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operand width,
// op encodings and FSM state encodings.
package hilo_muldiv_pkg;

   localparam int MD_XLEN = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ITER = 2'b01,
      ST_FIX  = 2'b10
   } md_state_e;

   function automatic logic op_is_signed(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-divide iteration: shift remainder:quotient left by one,
// trial-subtract the divisor and record the quotient bit.
module hilo_div_step
   import hilo_muldiv_pkg::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN:0] shifted;
   logic          fits;

   // The remainder is always below the divisor, so a successful trial result fits in XLEN bits.
   always_comb begin
      shifted = {rem_in, quo_in[XLEN-1]};
      fits    = (shifted >= {1'b0, divisor});
      rem_out = fits ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], fits};
   end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Define HILO_FAST_MUL_EN to complete multiplies through a single-cycle product.
module hilo_muldiv
   import hilo_muldiv_pkg::*;
#(
   parameter int XLEN  = MD_XLEN,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] reg1,
   input  logic [XLEN-1:0] reg2,
   input  logic            mthi_we,
   input  logic            mtlo_we,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   md_state_e         state_q, state_d;
   md_op_e            op_q, op_d;
   logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic              div_zero_q, div_zero_d, done_q, done_d;
   logic [XLEN-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b, div_rem, div_quo, quo_fix, rem_fix;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] prod_fix;

   hilo_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_in  (acc_q[2*XLEN-1:XLEN]),
      .quo_in  (acc_q[XLEN-1:0]),
      .divisor (mcand_q),
      .rem_out (div_rem),
      .quo_out (div_quo)
   );

   // Multiply keeps the multiplier in the low half of acc; divide keeps remainder:quotient.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      neg_a_d    = neg_a_q;
      neg_b_d    = neg_b_q;
      div_zero_d = div_zero_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      a_neg   = op_is_signed(md_op_e'(op)) & reg1[XLEN-1];
      b_neg   = op_is_signed(md_op_e'(op)) & reg2[XLEN-1];
      mag_a   = a_neg ? -reg1 : reg1;
      mag_b   = b_neg ? -reg2 : reg2;
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q & {XLEN{acc_q[0]}}};

      prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (div_zero_q) quo_fix = '1;

      case (state_q)
         ST_IDLE: begin
            if (mthi_we) hi_d = reg1;
            if (mtlo_we) lo_d = reg1;
            if (start) begin
               op_d       = md_op_e'(op);
               neg_a_d    = a_neg;
               neg_b_d    = b_neg;
               div_zero_d = (reg2 == '0);
               mcand_d    = op[1] ? mag_b : mag_a;
               acc_d      = {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
               cnt_d      = '0;
               state_d    = ST_ITER;
`ifdef HILO_FAST_MUL_EN
               if (!op[1]) begin
                  acc_d   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
                  state_d = ST_FIX;
               end
`endif
            end
         end
         ST_ITER: begin
            if (op_q inside {MD_DIV, MD_DIVU}) acc_d = {div_rem, div_quo};
            else                               acc_d = {mul_sum, acc_q[XLEN-1:1]};
            if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
            else                         cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_FIX: begin
            if (op_q inside {MD_DIV, MD_DIVU}) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= MD_MULT;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         div_zero_q <= 1'b0;
         mcand_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         neg_a_q    <= neg_a_d;
         neg_b_q    <= neg_b_d;
         div_zero_q <= div_zero_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed vector table, hand-written
// HI/LO hazard and reset sequences, and randomized ops against a reference model.
module tb_hilo_muldiv;
   import hilo_muldiv_pkg::*;

`ifdef HILO_FAST_MUL_EN
   localparam int LAT_MUL = 1;
`else
   localparam int LAT_MUL = 33;
`endif
   localparam int LAT_DIV = 33;

   logic        clk = 1'b0;
   logic        reset, start, mthi_we, mtlo_we;
   logic [1:0]  op;
   logic [31:0] reg1, reg2;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   hilo_muldiv dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .reg1    (reg1),
      .reg2    (reg2),
      .mthi_we (mthi_we),
      .mtlo_we (mtlo_we),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   vec_t vecs[9];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Result mapping from the op definitions, using plain integer arithmetic.
   function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb, q, r;
      longint      sp;
      logic [63:0] ua, ub;
      sa = a;
      sb = b;
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         2'b00: begin
            sp = longint'(sa) * longint'(sb);
            return sp;
         end
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Launch one op and wait (bounded) for done; latency counted in edges after the start edge.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rHi, output logic [31:0] rLo,
                                output int lat, output bit busyOk, output bit doneClean);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      reg1  = a;
      reg2  = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
      reg1   = $urandom;
      reg2   = $urandom;
      lat    = 0;
      busyOk = 1'b1;
      while (!done && lat < 100) begin
         if (!busy) busyOk = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      doneClean = done && !busy;
      rHi = hi;
      rLo = lo;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rHi, rLo, a, b;
      logic [1:0]  o;
      logic [63:0] exp;
      int          lat, pulses, expLat;
      bit          busyOk, doneClean;

      vecs[0] = '{"multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{"mult_m3x7", MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{"mult_minsq", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[3] = '{"div_m7d2",  MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4] = '{"divu_100d7", MD_DIVU, 32'd100,       32'd7,         32'd2,         32'd14};
      vecs[5] = '{"divu_5d0",  MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      vecs[6] = '{"div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[7] = '{"div_m5d0",  MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vecs[8] = '{"div_7dm2",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

      reset   = 1'b1;
      start   = 1'b0;
      op      = 2'b00;
      reg1    = '0;
      reg2    = '0;
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_hi", hi, 0);
      checkOutput("reset_lo", lo, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, rHi, rLo, lat, busyOk, doneClean);
         expLat = vecs[i].op[1] ? LAT_DIV : LAT_MUL;
         checkOutput({vecs[i].name, "_hi"}, rHi, vecs[i].expHi);
         checkOutput({vecs[i].name, "_lo"}, rLo, vecs[i].expLo);
         checkOutput({vecs[i].name, "_latency"}, lat, expLat);
         checkOutput({vecs[i].name, "_busy_held"}, busyOk, 1);
         checkOutput({vecs[i].name, "_done_not_busy"}, doneClean, 1);
      end

      // MTHI and MTLO together while idle, then MTHI alone.
      @(negedge clk);
      mthi_we = 1'b1;
      mtlo_we = 1'b1;
      reg1    = 32'h5555;
      @(posedge clk);
      #1;
      checkOutput("mthilo_both_hi", hi, 32'h5555);
      checkOutput("mthilo_both_lo", lo, 32'h5555);
      mtlo_we = 1'b0;
      reg1    = 32'h1234;
      @(posedge clk);
      #1;
      mthi_we = 1'b0;
      checkOutput("mthi_idle_hi", hi, 32'h1234);
      checkOutput("mthi_idle_lo", lo, 32'h5555);

      // DIV 9/4 with MTLO and a second start dropped while busy.
      @(negedge clk);
      start = 1'b1;
      op    = MD_DIV;
      reg1  = 32'd9;
      reg2  = 32'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 100) begin
         if (lat == 4) begin
            mtlo_we = 1'b1;
            start   = 1'b1;
            op      = MD_MULTU;
            reg1    = 32'hDEAD;
            reg2    = 32'd3;
         end else begin
            mtlo_we = 1'b0;
            start   = 1'b0;
         end
         if (lat == 6) checkOutput("mtlo_busy_dropped", lo, 32'h5555);
         @(posedge clk);
         #1;
         lat++;
      end
      mtlo_we = 1'b0;
      start   = 1'b0;
      checkOutput("hazard_div_latency", lat, LAT_DIV);
      checkOutput("hazard_div_lo", lo, 32'd2);
      checkOutput("hazard_div_hi", hi, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("hazard_no_queue_busy", busy, 0);

      // Reset at edge E10 of a DIV aborts it.
      @(negedge clk);
      start = 1'b1;
      op    = MD_DIV;
      reg1  = 32'hFFFF_FF9C;
      reg2  = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_hi", hi, 0);
      checkOutput("abort_lo", lo, 0);
      checkOutput("abort_done", done, 0);
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      checkOutput("abort_no_done", pulses, 0);
      applyStimulus(MD_DIVU, 32'd100, 32'd7, rHi, rLo, lat, busyOk, doneClean);
      checkOutput("after_abort_hi", rHi, 32'd2);
      checkOutput("after_abort_lo", rLo, 32'd14);
      checkOutput("after_abort_latency", lat, LAT_DIV);

      // Randomized ops against the reference model.
      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         exp = refModel(o, a, b);
         applyStimulus(o, a, b, rHi, rLo, lat, busyOk, doneClean);
         checkOutput($sformatf("rand%0d_op%0d_%h_%h", i, o, a, b), {rHi, rLo}, exp);
         checkOutput($sformatf("rand%0d_latency", i), lat, o[1] ? LAT_DIV : LAT_MUL);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
